// File: rtl/icache_store_lfsr.sv
// Storage and victim-select core for a 2-way instruction cache.
// Holds per-way tag/valid arrays, per-way-per-word data banks and a
// free-running 8-bit LFSR that proposes the replacement way. Every RAM is
// single-port, write-first, with a one-cycle registered read.
module icache_store_lfsr #(
  parameter int WAY       = 2,
  parameter int WORD_NUM  = 4,
  parameter int INDEX_LOG = 8,
  parameter int TAG_W     = 20,
  parameter int WAY_LOG   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WAY-1:0]                tagv_ena,
  input  logic                          tagv_wea,
  input  logic [INDEX_LOG-1:0]          tagv_addra,
  input  logic [TAG_W:0]                tagv_dina,
  output logic [WAY*(TAG_W+1)-1:0]      tagv_douta,
  input  logic [WAY*WORD_NUM-1:0]       bank_ena,
  input  logic [3:0]                    bank_wea,
  input  logic [INDEX_LOG-1:0]          bank_addra,
  input  logic [31:0]                   bank_dina,
  output logic [WAY*WORD_NUM*32-1:0]    bank_douta,
  output logic [WAY_LOG-1:0]            lfsr_out
);

  localparam int SETS   = 1 << INDEX_LOG;
  localparam int BANKS  = WAY * WORD_NUM;
  localparam int TAGV_W = TAG_W + 1;

  // ------------------------------------------------------------------
  // Tag/valid storage, one instance per way. The tag field is a plain
  // array (no reset, RAM-friendly); the valid field is a flop vector so
  // that reset can invalidate the whole way at once.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WAY; gi++) begin : g_tagv
      logic [TAG_W-1:0]  tag_mem [SETS];
      logic [SETS-1:0]   valid_reg;
      logic [TAGV_W-1:0] dout_reg;
      logic              rd_en;
      logic              wr_en;

      assign rd_en = tagv_ena[gi];
      assign wr_en = tagv_ena[gi] & tagv_wea;

      // Tag array write; an edge that sees rst high never commits a write.
      always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
          if (wr_en) begin
            tag_mem[tagv_addra] <= tagv_dina[TAGV_W-1:1];
          end
        end
      end

      // Valid bits: cleared wholesale by reset, otherwise follow writes.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= '0;
        end else if (wr_en) begin
          valid_reg[tagv_addra] <= tagv_dina[0];
        end
      end

      // Registered read port, write-first; holds when the way is idle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_reg <= '0;
        end else if (rd_en) begin
          if (wr_en) begin
            dout_reg <= tagv_dina;
          end else begin
            dout_reg <= {tag_mem[tagv_addra], valid_reg[tagv_addra]};
          end
        end
      end

      assign tagv_douta[gi*TAGV_W +: TAGV_W] = dout_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Data banks, one per (way, word). Bank b = way*WORD_NUM + word.
  // Byte enables are shared across banks; only enabled banks act.
  // ------------------------------------------------------------------
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic [31:0] data_mem [SETS];
      logic [31:0] word_next;
      logic [31:0] dout_reg;
      logic        rd_en;

      assign rd_en = bank_ena[gi];

      // Merge the write bytes over the stored word; with no byte enables
      // this is just the stored word, which makes wea=0 a pure read.
      always_comb begin
        word_next = data_mem[bank_addra];
        for (int k = 0; k < 4; k++) begin
          if (bank_wea[k]) begin
            word_next[k*8 +: 8] = bank_dina[k*8 +: 8];
          end
        end
      end

      // Byte-granular array write; suppressed on an edge that sees rst.
      always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
          if (rd_en) begin
            for (int k = 0; k < 4; k++) begin
              if (bank_wea[k]) begin
                data_mem[bank_addra][k*8 +: 8] <= bank_dina[k*8 +: 8];
              end
            end
          end
        end
      end

      // Registered read port returning the post-write word.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_reg <= '0;
        end else if (rd_en) begin
          dout_reg <= word_next;
        end
      end

      assign bank_douta[gi*32 +: 32] = dout_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Victim LFSR: x^8 + x^6 + x^5 + x^4 + 1, maximal length (255), seeded
  // with 1 so the all-zero lock-up state is unreachable. It runs every
  // cycle; the controller samples lfsr_out when it needs a victim.
  // ------------------------------------------------------------------
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;

  assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= 8'h01;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign lfsr_out = lfsr_reg[WAY_LOG-1:0];

endmodule

// File: tb/tb_icache_store_lfsr.sv
// Self-checking bench for icache_store_lfsr: directed scenarios followed
// by a randomized run against a behavioural array model.
module tb_icache_store_lfsr;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   tagv_ena;
  logic         tagv_wea;
  logic [7:0]   tagv_addra;
  logic [20:0]  tagv_dina;
  logic [41:0]  tagv_douta;
  logic [7:0]   bank_ena;
  logic [3:0]   bank_wea;
  logic [7:0]   bank_addra;
  logic [31:0]  bank_dina;
  logic [255:0] bank_douta;
  logic [0:0]   lfsr_out;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [19:0] m_tag   [2][256];
  logic        m_valid [2][256];
  logic [31:0] m_data  [8][256];
  logic [20:0] m_tdout [2];
  logic [31:0] m_bdout [8];

  icache_store_lfsr dut (
    .clk        (clk),
    .rst        (rst),
    .tagv_ena   (tagv_ena),
    .tagv_wea   (tagv_wea),
    .tagv_addra (tagv_addra),
    .tagv_dina  (tagv_dina),
    .tagv_douta (tagv_douta),
    .bank_ena   (bank_ena),
    .bank_wea   (bank_wea),
    .bank_addra (bank_addra),
    .bank_dina  (bank_dina),
    .bank_douta (bank_douta),
    .lfsr_out   (lfsr_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tagv_ena   = '0;
    tagv_wea   = 1'b0;
    tagv_addra = '0;
    tagv_dina  = '0;
    bank_ena   = '0;
    bank_wea   = '0;
    bank_addra = '0;
    bank_dina  = '0;
  endtask

  // Apply the storage rules for one clock edge using the current inputs.
  task automatic model_edge();
    for (int w = 0; w < 2; w++) begin
      if (tagv_ena[w]) begin
        if (tagv_wea) begin
          m_tag[w][tagv_addra]   = tagv_dina[20:1];
          m_valid[w][tagv_addra] = tagv_dina[0];
          m_tdout[w]             = tagv_dina;
        end else begin
          m_tdout[w] = {m_tag[w][tagv_addra], m_valid[w][tagv_addra]};
        end
      end
    end
    for (int b = 0; b < 8; b++) begin
      if (bank_ena[b]) begin
        logic [31:0] word;
        word = m_data[b][bank_addra];
        for (int k = 0; k < 4; k++)
          if (bank_wea[k]) word[k*8 +: 8] = bank_dina[k*8 +: 8];
        m_data[b][bank_addra] = word;
        m_bdout[b]            = word;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    n_checks++;
    if (tagv_douta !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_tagv_douta: got %h want 0", tagv_douta);
    end
    n_checks++;
    if (bank_douta !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_bank_douta: got %h want 0", bank_douta);
    end
    // write way0 set 5 and bank0 set 5
    rst        = 1'b0;
    tagv_ena   = 2'b01;
    tagv_wea   = 1'b1;
    tagv_addra = 8'd5;
    tagv_dina  = {20'hABCDE, 1'b1};
    bank_ena   = 8'h01;
    bank_wea   = 4'hF;
    bank_addra = 8'd5;
    bank_dina  = 32'h12345678;
    tick();
    n_checks++;
    if (tagv_douta[20:0] !== {20'hABCDE, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_prewrite_tagv: got %h want %h", tagv_douta[20:0], {20'hABCDE, 1'b1});
    end
    // asynchronous assertion mid-cycle with the write still presented
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (tagv_douta !== 42'd0 || bank_douta !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_async_clear: tagv %h bank0 %h want 0", tagv_douta, bank_douta[31:0]);
    end
    tick();   // edge with rst high and a write pending: discarded
    rst       = 1'b0;
    tagv_wea  = 1'b0;
    bank_ena  = '0;
    bank_wea  = '0;
    tick();
    n_checks++;
    if (tagv_douta[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_cleared: got %b want 0", tagv_douta[0]);
    end
    n_checks++;
    if (tagv_douta[41:21] !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_way1_hold: got %h want 0", tagv_douta[41:21]);
    end
    idle();
  endtask

  task automatic test_tagv();
    idle();
    tagv_ena   = 2'b10;
    tagv_wea   = 1'b1;
    tagv_addra = 8'hFF;
    tagv_dina  = {20'h12345, 1'b1};
    tick();
    n_checks++;
    if (tagv_douta[41:21] !== 21'h2468B) begin
      n_fail++;
      $display("FAIL tagv_write_first: got %h want 2468b", tagv_douta[41:21]);
    end
    tagv_ena = 2'b01;
    tagv_wea = 1'b0;
    tick();
    n_checks++;
    if (tagv_douta[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL tagv_way0_untouched: valid %b want 0", tagv_douta[0]);
    end
    tagv_ena = 2'b10;
    tick();
    n_checks++;
    if (tagv_douta[41:21] !== 21'h2468B) begin
      n_fail++;
      $display("FAIL tagv_readback: got %h want 2468b", tagv_douta[41:21]);
    end
    idle();
  endtask

  task automatic test_bank_byte();
    idle();
    bank_ena   = 8'hFF;
    bank_wea   = 4'hF;
    bank_addra = 8'd3;
    bank_dina  = 32'hCAFEF00D;
    tick();
    bank_ena  = 8'h04;   // way0 word2
    bank_dina = 32'hDEADBEEF;
    tick();
    n_checks++;
    if (bank_douta[2*32 +: 32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bank_full_write: got %h want deadbeef", bank_douta[2*32 +: 32]);
    end
    bank_wea  = 4'b0001;
    bank_dina = 32'h00000011;
    tick();
    n_checks++;
    if (bank_douta[2*32 +: 32] !== 32'hDEADBE11) begin
      n_fail++;
      $display("FAIL bank_byte_merge: got %h want deadbe11", bank_douta[2*32 +: 32]);
    end
    bank_ena = 8'hFF;
    bank_wea = 4'h0;
    tick();
    for (int b = 0; b < 8; b++) begin
      logic [31:0] want;
      want = (b == 2) ? 32'hDEADBE11 : 32'hCAFEF00D;
      n_checks++;
      if (bank_douta[b*32 +: 32] !== want) begin
        n_fail++;
        $display("FAIL bank_set3_read[%0d]: got %h want %h", b, bank_douta[b*32 +: 32], want);
      end
    end
    idle();
  endtask

  task automatic test_hold();
    idle();
    bank_ena   = 8'hFF;
    bank_addra = 8'd3;
    tick();
    bank_ena = 8'h00;
    bank_wea = 4'hF;
    tagv_wea = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bank_addra = 8'(c + 10);
      tagv_addra = 8'(c + 10);
      bank_dina  = $urandom;
      tagv_dina  = 21'($urandom);
      tick();
      for (int b = 0; b < 8; b++) begin
        logic [31:0] want;
        want = (b == 2) ? 32'hDEADBE11 : 32'hCAFEF00D;
        n_checks++;
        if (bank_douta[b*32 +: 32] !== want) begin
          n_fail++;
          $display("FAIL hold_cycle%0d_bank%0d: got %h want %h", c, b, bank_douta[b*32 +: 32], want);
        end
      end
    end
    // a disabled write must not have touched set 3
    idle();
    bank_ena   = 8'h04;
    bank_addra = 8'd3;
    bank_wea   = 4'h0;
    tick();
    n_checks++;
    if (bank_douta[2*32 +: 32] !== 32'hDEADBE11) begin
      n_fail++;
      $display("FAIL hold_mem_unchanged: got %h want deadbe11", bank_douta[2*32 +: 32]);
    end
    idle();
  endtask

  task automatic test_parallel();
    idle();
    bank_ena   = 8'hFF;
    bank_wea   = 4'hF;
    bank_addra = 8'd7;
    bank_dina  = 32'h55AA55AA;
    tick();
    bank_wea  = 4'h0;
    bank_dina = 32'h0;
    tick();
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (bank_douta[b*32 +: 32] !== 32'h55AA55AA) begin
        n_fail++;
        $display("FAIL parallel_bank%0d: got %h want 55aa55aa", b, bank_douta[b*32 +: 32]);
      end
    end
    idle();
  endtask

  task automatic test_lfsr();
    logic [7:0] s;
    logic [7:0] first_states [5];
    int ones;
    first_states = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    idle();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    s    = 8'h01;
    ones = 0;
    for (int i = 0; i < 255; i++) begin
      if (i < 5) begin
        n_checks++;
        if (dut.lfsr_reg !== first_states[i]) begin
          n_fail++;
          $display("FAIL lfsr_start%0d: state %h want %h", i, dut.lfsr_reg, first_states[i]);
        end
      end
      n_checks++;
      if (lfsr_out !== s[0] || dut.lfsr_reg === 8'h00) begin
        n_fail++;
        $display("FAIL lfsr_step%0d: out %b state %h want out %b state %h", i, lfsr_out, dut.lfsr_reg, s[0], s);
      end
      if (lfsr_out === 1'b1) ones++;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      tick();
    end
    n_checks++;
    if (dut.lfsr_reg !== 8'h01) begin
      n_fail++;
      $display("FAIL lfsr_period: state after 255 cycles %h want 01", dut.lfsr_reg);
    end
    n_checks++;
    if (ones != 128) begin
      n_fail++;
      $display("FAIL lfsr_ones_per_period: got %0d want 128", ones);
    end
  endtask

  task automatic test_random();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_tdout[w] = '0;
      for (int a = 0; a < 256; a++) m_valid[w][a] = 1'b0;
    end
    for (int b = 0; b < 8; b++) m_bdout[b] = '0;
    // give every set in the working range a known tag and word
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        tagv_ena   = (b < 2) ? 2'(1 << b) : 2'b00;
        tagv_wea   = 1'b1;
        tagv_addra = 8'(a);
        tagv_dina  = 21'($urandom);
        bank_ena   = 8'(1 << b);
        bank_wea   = 4'hF;
        bank_addra = 8'(a);
        bank_dina  = $urandom;
        tick();
        model_edge();
      end
    end
    for (int c = 0; c < 400; c++) begin
      logic [41:0]  want_t;
      logic [255:0] want_b;
      tagv_ena   = 2'($urandom);
      tagv_wea   = 1'($urandom);
      tagv_addra = 8'($urandom_range(0, 7));
      tagv_dina  = 21'($urandom);
      bank_ena   = 8'($urandom);
      bank_wea   = 4'($urandom);
      bank_addra = 8'($urandom_range(0, 7));
      bank_dina  = $urandom;
      tick();
      model_edge();
      want_t = {m_tdout[1], m_tdout[0]};
      for (int b = 0; b < 8; b++) want_b[b*32 +: 32] = m_bdout[b];
      n_checks++;
      if (tagv_douta !== want_t) begin
        n_fail++;
        $display("FAIL random%0d_tagv: got %h want %h", c, tagv_douta, want_t);
      end
      n_checks++;
      if (bank_douta !== want_b) begin
        n_fail++;
        $display("FAIL random%0d_bank: got %h want %h", c, bank_douta, want_b);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_tagv();
    test_bank_byte();
    test_hold();
    test_parallel();
    test_lfsr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_store_lfsr.md
Name: icache_store_lfsr

Overview:
- Storage and victim-select core of the 2-way instruction cache: per-way tag/valid RAMs (TAGV), per-way-per-word data bank RAMs (DATA), and a free-running LFSR that supplies the replacement way.
- All RAMs are single-port, synchronous, with one-cycle read latency.
- Sits beneath the cache controller FSM, which drives all enables, addresses and write data and consumes the registered outputs.

Parameters:
- WAY, 2, number of ways.
- WORD_NUM, 4, 32-bit words per line; one data bank per word per way.
- INDEX_LOG, 8, set index width (256 sets).
- TAG_W, 20, physical tag width; each TAGV entry is TAG_W+1 bits, {tag, valid}, with valid in bit 0.
- WAY_LOG, 1, victim select width (clog2 WAY).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tagv_ena  in  WAY  per-way TAGV enable.
- tagv_wea  in  1  TAGV write, shared by all ways; acts only where tagv_ena is set.
- tagv_addra  in  INDEX_LOG  TAGV set index, shared.
- tagv_dina  in  TAG_W+1  TAGV write data {tag, valid}.
- tagv_douta  out  WAY*(TAG_W+1)  TAGV read data; way w in slice [w*(TAG_W+1) +: TAG_W+1].
- bank_ena  in  WAY*WORD_NUM  bank enables; bit w*WORD_NUM+j selects way w, word j.
- bank_wea  in  4  byte write enables, shared by all banks.
- bank_addra  in  INDEX_LOG  bank set index, shared.
- bank_dina  in  32  bank write data.
- bank_douta  out  WAY*WORD_NUM*32  bank read data; bank (w,j) in slice [(w*WORD_NUM+j)*32 +: 32].
- lfsr_out  out  WAY_LOG  pseudo-random victim way.

Behaviour:
- TAGV storage per way:
  - tag field: array of 2^INDEX_LOG x TAG_W, not reset.
  - valid field: register array of 2^INDEX_LOG bits, asynchronously cleared by rst.
- Data banks: arrays of 2^INDEX_LOG x 32, not reset.
- Read, when ena=1 and no write: douta is registered and equals mem[addra] in the cycle after the edge.
- Write, when ena=1 and write enable active: write-first.
  - TAGV: when tagv_wea=1, mem[addra] <= dina and douta <= dina.
  - Data: byte k is written only where bank_wea[k]=1; douta <= the merged new word.
  - bank_wea=0000 with ena=1 is a pure read.
- ena=0: douta holds its previous value; memory is unchanged regardless of the write enables.
- Ways and banks are fully independent; any subset of enables may be active in the same cycle.
- Reset, asserted at any time including mid-write:
  - all douta registers go to 0;
  - all valid bits go to 0;
  - a write coincident with rst is discarded.
- After reset, a read of any set returns valid=0 until that entry is written. Tag and data contents after reset are don't-care.
- LFSR:
  - internal 8-bit state s, reset to 8'h01;
  - every cycle s <= {s[6:0], s[7]^s[5]^s[4]^s[3]};
  - lfsr_out = s[WAY_LOG-1:0];
  - free-running with no enable; the controller latches lfsr_out when it needs a stable victim;
  - the state never reaches 0; period is 255.
- No combinational path from any input to any output.

Test Plan:
- Reset clears valid: assert rst, write TAGV way0 set 5 with {20'hABCDE,1}, then rst again. A read of set 5 the next cycle returns valid=0 in bit 0, and tagv_douta=0 directly after reset.
- TAGV write/read: write way1 set 0xFF {20'h12345,1} with only tagv_ena[1]=1.
  - Same-cycle output, write-first: 21'h2468B.
  - Read of way0 set 0xFF returns valid=0.
- Bank byte write: write bank (way0, word2) set 3 with 32'hDEADBEEF, wea=1111, then 32'h00000011 with wea=0001. The next read returns 32'hDEADBE11; other banks at set 3 are unchanged.
- Hold on disable: read set 3, then drop all enables and toggle the addresses. douta stays at the set-3 data for the next 3 cycles.
- Parallel ways: enable all 8 bank bits and write set 7 with 32'h55AA55AA. A read of set 7 returns that word in all 8 bank_douta slices.
- LFSR sequence after reset: state 01, 02, 04, 08, 11 over successive cycles, so lfsr_out = 1, 0, 0, 0, 1. Over 255 cycles the state never equals 0 and returns to 01 at cycle 255.
